// File: rtl/branch_cmp_pkg.sv
// rtl/branch_cmp_pkg.sv - funct3 codes, FSM/cascade enums and branch decode helpers
package branch_cmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_e;

  // 010/011 are the two unused branch encodings
  function automatic logic is_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  function automatic logic is_signed(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input cmp_e c);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = (c == CMP_EQ);
      F3_BNE:           t = (c != CMP_EQ);
      F3_BLT, F3_BLTU:  t = (c == CMP_LT);
      F3_BGE, F3_BGEU:  t = (c != CMP_LT);
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/nibble_cascade_cell.sv
// rtl/nibble_cascade_cell.sv - one digit of a magnitude compare cascade
module nibble_cascade_cell
  import branch_cmp_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  cmp_e             i_casc,
  output cmp_e             o_casc
);

  // A differing digit overrides whatever the less significant digits decided
  always_comb begin
    o_casc = i_casc;
    if (i_a > i_b)      o_casc = CMP_GT;
    else if (i_a < i_b) o_casc = CMP_LT;
  end

endmodule

// File: rtl/branch_cmp_serial.sv
// rtl/branch_cmp_serial.sv - serial RV32I branch comparator, one digit per cycle LSB first
module branch_cmp_serial
  import branch_cmp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DIGIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_taken,
  output logic            o_gt,
  output logic            o_eq,
  output logic            o_lt,
  output logic            o_illegal
);

  localparam int STEPS = XLEN / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e            state_q;
  cmp_e              casc_q;
  cmp_e              casc_d;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   sign_mask;

  // Flipping both MSBs maps two's-complement order onto unsigned order
  assign sign_mask = {is_signed(i_funct3), {(XLEN-1){1'b0}}};

  nibble_cascade_cell #(
    .DIGIT (DIGIT)
  ) u_cell (
    .i_a    (a_q[DIGIT-1:0]),
    .i_b    (b_q[DIGIT-1:0]),
    .i_casc (casc_q),
    .o_casc (casc_d)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      casc_q    <= CMP_EQ;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_taken   <= 1'b0;
      o_gt      <= 1'b0;
      o_eq      <= 1'b0;
      o_lt      <= 1'b0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            state_q <= RUN;
            a_q     <= i_a ^ sign_mask;
            b_q     <= i_b ^ sign_mask;
            f3_q    <= i_funct3;
            casc_q  <= CMP_EQ;
            cnt_q   <= '0;
            o_ready <= 1'b0;
          end
        end
        RUN: begin
          casc_q <= casc_d;
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(STEPS - 1)) begin
            state_q   <= DONE;
            o_valid   <= 1'b1;
            o_gt      <= (casc_d == CMP_GT);
            o_eq      <= (casc_d == CMP_EQ);
            o_lt      <= (casc_d == CMP_LT);
            o_illegal <= is_illegal(f3_q);
            o_taken   <= branch_taken(f3_q, casc_d);
          end
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_cmp_serial.md
Name: branch_cmp_serial

Overview:
- Multi-cycle 32-bit branch comparator for the RV32I execute stage.
- Accepts two register operands and a branch funct3 over a valid/ready handshake.
- Resolves magnitude one nibble per cycle, least-significant nibble first, carrying gt/eq/lt cascade state between cycles.
- Returns the branch decision plus raw gt/eq/lt flags. Replaces a wide combinational compare where timing or area is tight.

Parameters:
- XLEN, 32, operand width; must be a multiple of DIGIT.
- DIGIT, 4, bits resolved per cycle; STEPS = XLEN/DIGIT compare cycles (8 at defaults).

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  asynchronous reset, active-high
- i_valid  input  1  request valid
- o_ready  output  1  block can accept a request
- i_a  input  XLEN  operand rs1
- i_b  input  XLEN  operand rs2
- i_funct3  input  3  branch funct3
- i_flush  input  1  synchronous abort of any in-flight or pending result
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_taken  output  1  branch condition true
- o_gt  output  1  a > b under the selected signedness
- o_eq  output  1  a == b
- o_lt  output  1  a < b under the selected signedness
- o_illegal  output  1  funct3 is 010 or 011

Behaviour:
- Reset (async, i_rst=1):
  - State = IDLE; step counter = 0; cascade = eq.
  - Outputs: o_ready=1, o_valid=0, o_taken=0, o_gt=0, o_eq=0, o_lt=0, o_illegal=0.
  - Reset mid-operation discards the in-flight request with no result produced.
- States:
  - IDLE: o_ready=1.
  - RUN: o_ready=0, o_valid=0.
  - DONE: o_ready=0, o_valid=1.
- IDLE→RUN on i_valid & o_ready & !i_flush. Capture on that edge:
  - a, b, funct3.
  - signed = (funct3[2:1]==2'b10), i.e. BLT/BGE.
  - If signed, invert bit XLEN-1 of both captured operands, so signed order maps onto unsigned order.
  - Cascade set to eq (gt=0, eq=1, lt=0); counter = 0.
- RUN, each cycle, for nibble k = counter:
  - a_k > b_k → cascade = gt.
  - a_k < b_k → cascade = lt.
  - a_k == b_k → cascade unchanged.
  - Counter increments. Higher nibbles override lower ones, so after STEPS cycles the cascade is the full-width result.
- RUN→DONE on the edge where counter == STEPS-1.
  - Fixed latency: accept edge at cycle t gives o_valid high from cycle t+STEPS (t+8).
  - No early termination.
- DONE outputs:
  - o_gt, o_eq, o_lt: the final cascade, exactly one high.
  - o_illegal = (funct3 is 010 or 011).
  - o_taken by funct3: 000 → eq; 001 → !eq; 100 or 110 → lt; 101 or 111 → !lt; 010/011 → 0.
- DONE→IDLE on i_ready.
  - Outputs are held stable while o_valid=1 and i_ready=0.
  - No new accept in the same cycle as result retirement; o_ready rises the cycle after.
- After retirement (DONE→IDLE):
  - Output flags are not required to hold.
  - Bench samples flags only when o_valid=1.
- i_flush has priority over everything except reset:
  - Any state → IDLE at the next edge; o_valid drops.
  - An i_valid presented with i_flush is not accepted.
- Input changes on i_a/i_b/i_funct3 after the accept edge have no effect.

Decomposition:
- Shared package branch_cmp_pkg:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - State enum {IDLE, RUN, DONE}.
  - Cascade enum {CMP_LT, CMP_EQ, CMP_GT}.
- One combinational sub-module, nibble_cascade_cell. It takes a DIGIT-bit a/b pair plus the incoming cascade, and returns the outgoing cascade. It is instantiated once and fed by a shifting operand register.

Test Plan:
- BLT (100), a=0xFFFFFFFF (-1), b=0x00000001 → o_valid at accept+8, o_lt=1, o_taken=1.
- BLTU (110), same operands → o_gt=1, o_taken=0. BGEU (111) → o_taken=1.
- BEQ (000), a=b=0x80000000 → o_eq=1, o_taken=1. BNE (001) with a=0x10, b=0x01 → o_gt=1, o_taken=1.
- Backpressure: BGE (101), a=5, b=5, i_ready held low 4 cycles → o_valid, o_taken=1, flags all stable. o_ready=1 only the cycle after i_ready is sampled high.
- Abort: assert i_rst at accept+3, then separately i_flush at accept+5 → o_valid never rises, o_ready=1 next cycle. A fresh BLTU 2 vs 3 then completes with o_taken=1.
- Illegal funct3=010, a=1, b=2 → o_valid at accept+8, o_illegal=1, o_taken=0, o_lt=1.
